mux_2to1: RTL and testbench



---
 rtl/mux_pkg.sv | 7 +
 rtl/mux_2to1_nand2.sv | 10 +
 rtl/mux_2to1.sv | 68 ++++++
 tb/tb_mux_2to1.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the NAND-only registered 2-to-1 multiplexer.
package mux_pkg;

  localparam int   MUX_DEFAULT_WIDTH = 1;
  localparam logic MUX_RESET_VAL     = 1'b0;

endpackage : mux_pkg

// File: rtl/mux_2to1_nand2.sv
// One-bit 2-input NAND: the only logic primitive in the mux select path.
module nand2 (
  output logic y,
  input  logic a1,
  input  logic a2
);

  assign y = ~(a1 & a2);

endmodule : nand2

// File: rtl/mux_2to1.sv
// Registered WIDTH-bit 2-to-1 mux; the select path is built purely from nand2 cells,
// and the result is also registered behind an asynchronous active-low reset.
module mux_2to1
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z_comb,
  output logic [WIDTH-1:0] z
);

  logic             ns_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] z_comb_s;
  logic [WIDTH-1:0] z_d;
  logic [WIDTH-1:0] z_q;

  // A single inverted select, formed as NAND(sel, sel), feeds every slice.
  nand2 u_nand_ns (
    .y  (ns_s),
    .a1 (sel),
    .a2 (sel)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    nand2 u_nand_p (
      .y  (p_s[i]),
      .a1 (a[i]),
      .a2 (ns_s)
    );

    nand2 u_nand_q (
      .y  (q_s[i]),
      .a1 (b[i]),
      .a2 (sel)
    );

    nand2 u_nand_z (
      .y  (z_comb_s[i]),
      .a1 (p_s[i]),
      .a2 (q_s[i])
    );
  end : g_slice

  // Output register loads every cycle.
  always_comb begin
    z_d = z_comb_s;
  end

  // Output register; reset clears it immediately with no retained value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= {WIDTH{MUX_RESET_VAL}};
    end else begin
      z_q <= z_d;
    end
  end

  assign z_comb = z_comb_s;
  assign z      = z_q;

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1 at WIDTH=1 and WIDTH=8 against a behavioural select model.
module tb_mux_2to1;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic [0:0] a1, b1, zc1, z1;
  logic [7:0] a8, b8, zc8, z8;

  int checks;
  int errors;

  mux_2to1 #(.WIDTH(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel    (sel),
    .a      (a1),
    .b      (b1),
    .z_comb (zc1),
    .z      (z1)
  );

  mux_2to1 #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel    (sel),
    .a      (a8),
    .b      (b8),
    .z_comb (zc8),
    .z      (z8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ref_mux(input logic s, input logic [7:0] x, input logic [7:0] y);
    return s ? y : x;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    sel   = 1'b1;
    a1    = 1'b0;
    b1    = 1'b1;
    a8    = 8'h12;
    b8    = 8'h34;
    #1;
    checks++;
    if (z1 !== 1'b0) begin errors++; $display("FAIL reset_z1: got %h expected %h", z1, 1'b0); end
    checks++;
    if (zc1 !== 1'b1) begin errors++; $display("FAIL reset_zcomb1: got %h expected %h", zc1, 1'b1); end
    checks++;
    if (z8 !== 8'h00) begin errors++; $display("FAIL reset_z8: got %h expected %h", z8, 8'h00); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (z1 !== 1'b0) begin errors++; $display("FAIL reset_hold_z1: got %h expected %h", z1, 1'b0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (z1 !== 1'b1) begin errors++; $display("FAIL reset_release_z1: got %h expected %h", z1, 1'b1); end
  endtask

  task automatic test_exhaustive_w1();
    logic [7:0] exp_tbl;
    logic [2:0] vec;
    logic       e;
    exp_tbl = 8'hAC;
    for (int v = 0; v < 8; v++) begin
      vec = 3'(v);
      @(negedge clk);
      sel = vec[2];
      a1  = vec[1];
      b1  = vec[0];
      e   = exp_tbl[v];
      #1;
      checks++;
      if (zc1 !== e) begin errors++; $display("FAIL sweep_zcomb v=%0d: got %h expected %h", v, zc1, e); end
      @(posedge clk);
      #1;
      checks++;
      if (z1 !== e) begin errors++; $display("FAIL sweep_z v=%0d: got %h expected %h", v, z1, e); end
    end
  endtask

  task automatic test_midrun_reset();
    @(negedge clk);
    sel = 1'b1;
    a1  = 1'b0;
    b1  = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (z1 !== 1'b1) begin errors++; $display("FAIL midrun_pre: got %h expected %h", z1, 1'b1); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (z1 !== 1'b0) begin errors++; $display("FAIL midrun_async_clear: got %h expected %h", z1, 1'b0); end
    checks++;
    if (zc1 !== 1'b1) begin errors++; $display("FAIL midrun_zcomb: got %h expected %h", zc1, 1'b1); end
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (z1 !== 1'b0) begin errors++; $display("FAIL midrun_no_reload_early: got %h expected %h", z1, 1'b0); end
    @(posedge clk);
    #1;
    checks++;
    if (z1 !== 1'b1) begin errors++; $display("FAIL midrun_reload: got %h expected %h", z1, 1'b1); end
  endtask

  task automatic test_w8_fixed();
    logic [7:0] e;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      a8  = 8'hA5;
      b8  = 8'h3C;
      sel = (s == 1);
      e   = (s == 1) ? 8'h3C : 8'hA5;
      #1;
      checks++;
      if (zc8 !== e) begin errors++; $display("FAIL w8_zcomb sel=%0d: got %h expected %h", s, zc8, e); end
      @(posedge clk);
      #1;
      checks++;
      if (z8 !== e) begin errors++; $display("FAIL w8_z sel=%0d: got %h expected %h", s, z8, e); end
    end
  endtask

  task automatic test_toggle();
    logic [7:0] prev_e;
    logic [7:0] e;
    a8     = 8'hFF;
    b8     = 8'h00;
    prev_e = z8;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      sel = c[0];
      e   = c[0] ? 8'h00 : 8'hFF;
      #1;
      if (c > 0) begin
        checks++;
        if (z8 !== prev_e) begin errors++; $display("FAIL toggle_lag c=%0d: got %h expected %h", c, z8, prev_e); end
      end
      @(posedge clk);
      #1;
      checks++;
      if (z8 !== e) begin errors++; $display("FAIL toggle_z c=%0d: got %h expected %h", c, z8, e); end
      prev_e = e;
    end
  endtask

  task automatic test_random();
    logic [7:0] e8, prev8;
    logic       e1;
    prev8 = z8;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      sel = 1'($urandom_range(1, 0));
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      a1  = 1'($urandom_range(1, 0));
      b1  = 1'($urandom_range(1, 0));
      e8  = ref_mux(sel, a8, b8);
      e1  = sel ? b1 : a1;
      #1;
      checks++;
      if (zc8 !== e8) begin errors++; $display("FAIL rand_zcomb8 n=%0d: got %h expected %h", n, zc8, e8); end
      checks++;
      if (zc1 !== e1) begin errors++; $display("FAIL rand_zcomb1 n=%0d: got %h expected %h", n, zc1, e1); end
      checks++;
      if (z8 !== prev8) begin errors++; $display("FAIL rand_hold8 n=%0d: got %h expected %h", n, z8, prev8); end
      @(posedge clk);
      #1;
      checks++;
      if (z8 !== e8) begin errors++; $display("FAIL rand_z8 n=%0d: got %h expected %h", n, z8, e8); end
      checks++;
      if (z1 !== e1) begin errors++; $display("FAIL rand_z1 n=%0d: got %h expected %h", n, z1, e1); end
      prev8 = e8;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    sel    = 1'b0;
    a1     = 1'b0;
    b1     = 1'b0;
    a8     = 8'h00;
    b8     = 8'h00;
    test_reset();
    test_exhaustive_w1();
    test_midrun_reset();
    test_w8_fixed();
    test_toggle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mux_2to1
